// File: rtl/nibble_serial_adder.sv
// Wide adder that walks one nibble per clock, LSB first; done_sig pulses NIB cycles after start.
// start_sig is only honoured in IDLE. Define SIGNED_OVF_EN to add the ovf_out overflow flag.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done_sig,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;
  logic             last;
`ifdef SIGNED_OVF_EN
  logic [3:0]       low3_sum;
`endif

  always_comb begin
    a_nib     = '0;
    b_nib     = '0;
    acc_nxt   = acc_q;
    state_nxt = state;
    // Explicit compare mux keeps the nibble select legal for every NIB, including 1.
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        acc_nxt[i*4 +: 4] = nib_sum[3:0];
      end
    end
    last = (idx_q == IW'(NIB - 1));
    case (state)
      IDLE:    if (start_sig) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SIGNED_OVF_EN
  // Bit 3 of this partial sum is the carry into the operand MSB.
  always_comb begin
    low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done_sig  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_sig) begin
            a_q     <= a_in;
            b_q     <= b_in;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= nib_sum[4];
          if (last) begin
            idx_q     <= '0;
            sum_out   <= acc_nxt;
            carry_out <= nib_sum[4];
            done_sig  <= 1'b1;
`ifdef SIGNED_OVF_EN
            ovf_out   <= low3_sum[3] ^ nib_sum[4];
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_sig <= 1'b0;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: 16-bit and 4-bit instances driven and sampled on the falling edge.
module tb_nibble_serial_adder;

  logic        CLK;
  logic        RSTn;
  logic        start_sig, start4;
  logic [15:0] a_in, b_in, sum_out;
  logic [3:0]  a4, b4, sum4;
  logic        busy, done_sig, carry_out;
  logic        busy4, done4, carry4;
`ifdef SIGNED_OVF_EN
  logic        ovf_out, ovf4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .start_sig(start_sig), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done_sig(done_sig), .sum_out(sum_out), .carry_out(carry_out)
`ifdef SIGNED_OVF_EN
    , .ovf_out(ovf_out)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .start_sig(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done_sig(done4), .sum_out(sum4), .carry_out(carry4)
`ifdef SIGNED_OVF_EN
    , .ovf_out(ovf4)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns falling edges until done_sig (NIB+1 expected) and whether sum_out held meanwhile.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, output int lat, output logic held_ok);
    logic [15:0] prev;
    prev      = sum_out;
    held_ok   = 1'b1;
    lat       = 0;
    a_in      = a;
    b_in      = b;
    start_sig = 1'b1;
    do begin
      @(negedge CLK);
      start_sig = 1'b0;
      lat++;
      if (!done_sig && sum_out !== prev) held_ok = 1'b0;
    end while (!done_sig && lat < 20);
  endtask

  initial begin
    int   lat, k, dones;
    logic held;
    RSTn = 1'b0; start_sig = 1'b0; a_in = '0; b_in = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_sig, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst4_sum", sum4, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    // 0x1234 + 0x1111
    do_add(16'h1234, 16'h1111, lat, held);
    chk("t1_latency", lat, 5);
    chk("t1_sum", sum_out, 16'h2345);
    chk("t1_carry", carry_out, 0);
    chk("t1_busy_at_done", busy, 1);
    chk("t1_held", held, 1);
    @(negedge CLK);
    chk("t1_done_drop", done_sig, 0);
    chk("t1_busy_drop", busy, 0);

    // Unsigned wrap with carry out
    do_add(16'hFFFF, 16'h0001, lat, held);
    chk("t2_latency", lat, 5);
    chk("t2_sum", sum_out, 16'h0000);
    chk("t2_carry", carry_out, 1);
    chk("t2_held", held, 1);
`ifdef SIGNED_OVF_EN
    chk("t2_ovf", ovf_out, 0);
`endif
    @(negedge CLK);
`ifdef SIGNED_OVF_EN
    do_add(16'h7FFF, 16'h0001, lat, held);
    chk("t2b_sum", sum_out, 16'h8000);
    chk("t2b_ovf", ovf_out, 1);
    chk("t2b_carry", carry_out, 0);
    @(negedge CLK);
    chk("t2b_ovf_held", ovf_out, 1);
`endif

    // Operand change and second start while running are ignored
    a_in = 16'h00F0; b_in = 16'h0010; start_sig = 1'b1;
    @(negedge CLK); start_sig = 1'b0;
    @(negedge CLK); a_in = 16'hFFFF; b_in = 16'hFFFF; start_sig = 1'b1;
    @(negedge CLK); start_sig = 1'b0;
    @(negedge CLK);
    chk("t3_no_early_done", done_sig, 0);
    @(negedge CLK);
    chk("t3_done", done_sig, 1);
    chk("t3_sum", sum_out, 16'h0100);
    chk("t3_carry", carry_out, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done_sig) dones++;
    end
    chk("t3_no_extra_done", dones, 0);
    chk("t3_idle", busy, 0);

    // Asynchronous reset between E2 and E3
    a_in = 16'h1234; b_in = 16'h4321; start_sig = 1'b1;
    @(negedge CLK); start_sig = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done_sig, 0);
    chk("t4_rst_sum", sum_out, 0);
    chk("t4_rst_carry", carry_out, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done_sig) dones++;
    end
    chk("t4_no_done_after", dones, 0);
    do_add(16'h0F0F, 16'h0101, lat, held);
    chk("t4_latency", lat, 5);
    chk("t4_sum", sum_out, 16'h1010);
    chk("t4_carry", carry_out, 0);
    @(negedge CLK);

    // Back-to-back with start held high: accepts every 6 cycles
    a_in = 16'h1000; b_in = 16'h0001; start_sig = 1'b1;
    dones = 0;
    for (k = 1; k <= 17; k++) begin
      @(negedge CLK);
      if (k == 8) chk("t5_held_while_busy", sum_out, 16'h1001);
      if (done_sig) begin
        dones++;
        if (dones == 1) begin
          chk("t5_done1_at", k, 5);
          chk("t5_sum1", sum_out, 16'h1001);
          a_in = 16'h2222; b_in = 16'h1111;
        end else if (dones == 2) begin
          chk("t5_done2_at", k, 11);
          chk("t5_sum2", sum_out, 16'h3333);
          a_in = 16'hFFF0; b_in = 16'h0020;
        end else begin
          chk("t5_done3_at", k, 17);
          chk("t5_sum3", sum_out, 16'h0010);
          chk("t5_carry3", carry_out, 1);
        end
      end
    end
    start_sig = 1'b0;
    chk("t5_done_count", dones, 3);
    repeat (3) @(negedge CLK);
    chk("t5_idle", busy, 0);

    // WIDTH=4 instance: single RUN cycle
    a4 = 4'h9; b4 = 4'h8; start4 = 1'b1;
    @(negedge CLK); start4 = 1'b0;
    chk("w4_busy", busy4, 1);
    chk("w4_no_early_done", done4, 0);
    @(negedge CLK);
    chk("w4_done", done4, 1);
    chk("w4_sum", sum4, 4'h1);
    chk("w4_carry", carry4, 1);
    @(negedge CLK);
    chk("w4_done_drop", done4, 0);
    chk("w4_busy_drop", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
